// File: rtl/raid_pkg.sv
// Shared RAID controller definitions: mode codes, FSM state encoding and
// the rotating-parity lane helper.
package raid_pkg;

  localparam logic [3:0] MODE_RAID1 = 4'd0;
  localparam logic [3:0] MODE_RAID0 = 4'd1;
  localparam logic [3:0] MODE_RAID5 = 4'd5;

  localparam int PL_AW = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Lane that holds parity for a given block address.
  function automatic int parity_lane(input logic [PL_AW-1:0] addr, input int ndrives);
    return int'(addr % PL_AW'(ndrives));
  endfunction

endpackage

// File: rtl/raid_vote.sv
// Combinational majority vote across the healthy mirrors of a RAID1 read.
module raid_vote #(
  parameter int NDRIVES = 4,
  parameter int HW      = 32
) (
  input  logic [NDRIVES*HW-1:0] data_i,
  input  logic [NDRIVES-1:0]    healthy_i,
  output logic [HW-1:0]         winner_o,
  output logic                  mismatch_o,
  output logic                  no_majority_o
);

  int          healthy_cnt;
  int          match_cnt;
  logic        found;
  logic [HW-1:0] winner;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    winner      = '0;
    found       = 1'b0;
    match_cnt   = 0;
    mismatch_o  = 1'b0;
    healthy_cnt = $countones(healthy_i);

    // Lowest-index healthy drive backed by a strict majority wins.
    for (int i = 0; i < NDRIVES; i++) begin
      if (healthy_i[i] && !found) begin
        match_cnt = 0;
        for (int j = 0; j < NDRIVES; j++) begin
          if (healthy_i[j] && (data_i[j*HW +: HW] == data_i[i*HW +: HW])) match_cnt++;
        end
        if (2 * match_cnt > healthy_cnt) begin
          found  = 1'b1;
          winner = data_i[i*HW +: HW];
        end
      end
    end

    if (found) begin
      for (int j = 0; j < NDRIVES; j++) begin
        if (healthy_i[j] && (data_i[j*HW +: HW] != winner)) mismatch_o = 1'b1;
      end
    end

    winner_o      = winner;
    no_majority_o = !found;
  end

endmodule

// File: rtl/raid_array_ctrl.sv
// RAID0/1/5 controller: accepts one host request, fans it out to the drive
// lanes, waits for the selected drives with a watchdog, and returns one response.
module raid_array_ctrl
  import raid_pkg::*;
#(
  parameter int NDRIVES     = 4,
  parameter int SW          = 8,
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              mode,
  input  logic [NDRIVES-1:0]      drive_fail,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AW-1:0]           req_addr,
  input  logic [NDRIVES*SW-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [NDRIVES*SW-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_mismatch,
  output logic                    rsp_timeout,
  output logic                    drv_rd,
  output logic                    drv_wr,
  output logic [NDRIVES-1:0]      drv_sel,
  output logic [AW-1:0]           drv_addr,
  output logic [NDRIVES*NDRIVES*SW-1:0] drv_wdata,
  input  logic [NDRIVES*NDRIVES*SW-1:0] drv_rdata,
  input  logic [NDRIVES-1:0]      drv_busy
);

  localparam int HW = NDRIVES * SW;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_e                 state_q;
  logic                   req_ready_q, rsp_valid_q, rsp_err_q, rsp_mismatch_q, rsp_timeout_q;
  logic [HW-1:0]          rsp_rdata_q;
  logic                   drv_rd_q, drv_wr_q;
  logic [NDRIVES-1:0]     drv_sel_q, fail_q;
  logic [AW-1:0]          drv_addr_q;
  logic [NDRIVES*HW-1:0]  drv_wdata_q;
  logic                   write_q;
  logic [3:0]             mode_q;
  logic [CW-1:0]          cnt_q;

  logic                   pre_err_d;
  logic [NDRIVES*HW-1:0]  wr_lanes_d;
  logic [SW-1:0]          wr_parity;
  int                     acc_p;

  logic [HW-1:0]          rd_data_d;
  logic                   rd_err_d, rd_mis_d;
  logic [SW-1:0]          rd_xor, rd_lane;
  int                     rd_p;

  logic [HW-1:0]          vote_win;
  logic                   vote_mis, vote_nomaj;

  // Accept-time decisions: pre-check and lane placement of write data.
  always_comb begin
    pre_err_d  = 1'b0;
    wr_lanes_d = '0;
    wr_parity  = '0;
    acc_p      = parity_lane(PL_AW'(req_addr), NDRIVES);

    case (mode)
      MODE_RAID0: pre_err_d = |drive_fail;
      MODE_RAID1: pre_err_d = &drive_fail;
      MODE_RAID5: pre_err_d = ($countones(drive_fail) > 1);
      default:    pre_err_d = 1'b1;
    endcase

    for (int k = 0; k < NDRIVES - 1; k++) wr_parity ^= req_wdata[k*SW +: SW];

    for (int i = 0; i < NDRIVES; i++) begin
      if (!drive_fail[i]) begin
        case (mode)
          MODE_RAID0: wr_lanes_d[i*HW +: SW] = req_wdata[i*SW +: SW];
          MODE_RAID1: wr_lanes_d[i*HW +: HW] = req_wdata;
          MODE_RAID5: begin
            if (i < acc_p)      wr_lanes_d[i*HW +: SW] = req_wdata[i*SW +: SW];
            else if (i > acc_p) wr_lanes_d[i*HW +: SW] = req_wdata[(i-1)*SW +: SW];
            else                wr_lanes_d[i*HW +: SW] = wr_parity;
          end
          default: ;
        endcase
      end
    end
  end

  raid_vote #(.NDRIVES(NDRIVES), .HW(HW)) u_vote (
    .data_i        (drv_rdata),
    .healthy_i     (~fail_q),
    .winner_o      (vote_win),
    .mismatch_o    (vote_mis),
    .no_majority_o (vote_nomaj)
  );

  // Read response assembly; a failed RAID5 lane is the XOR of the healthy ones.
  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    rd_mis_d  = 1'b0;
    rd_xor    = '0;
    rd_lane   = '0;
    rd_p      = parity_lane(PL_AW'(drv_addr_q), NDRIVES);

    for (int i = 0; i < NDRIVES; i++) begin
      if (!fail_q[i]) rd_xor ^= drv_rdata[i*HW +: SW];
    end

    case (mode_q)
      MODE_RAID0: begin
        for (int i = 0; i < NDRIVES; i++) rd_data_d[i*SW +: SW] = drv_rdata[i*HW +: SW];
      end
      MODE_RAID1: begin
        if (vote_nomaj) begin
          rd_data_d = '1;
          rd_err_d  = 1'b1;
        end else begin
          rd_data_d = vote_win;
          rd_mis_d  = vote_mis;
        end
      end
      MODE_RAID5: begin
        rd_mis_d = (fail_q == '0) && (rd_xor != '0);
        for (int i = 0; i < NDRIVES; i++) begin
          rd_lane = fail_q[i] ? rd_xor : drv_rdata[i*HW +: SW];
          if (i < rd_p)      rd_data_d[i*SW +: SW]     = rd_lane;
          else if (i > rd_p) rd_data_d[(i-1)*SW +: SW] = rd_lane;
        end
      end
      default: rd_err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_mismatch_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      rsp_rdata_q    <= '0;
      drv_rd_q       <= 1'b0;
      drv_wr_q       <= 1'b0;
      drv_sel_q      <= '0;
      drv_addr_q     <= '0;
      drv_wdata_q    <= '0;
      fail_q         <= '0;
      write_q        <= 1'b0;
      mode_q         <= '0;
      cnt_q          <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            mode_q      <= mode;
            fail_q      <= drive_fail;
            drv_addr_q  <= req_addr;
            if (pre_err_d) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= ST_ISSUE;
              drv_rd_q    <= !req_write;
              drv_wr_q    <= req_write;
              drv_sel_q   <= ~drive_fail;
              drv_wdata_q <= req_write ? wr_lanes_d : '0;
            end
          end
        end
        ST_ISSUE: begin
          drv_rd_q <= 1'b0;
          drv_wr_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if ((drv_busy & drv_sel_q) == '0) begin
            state_q        <= ST_RESP;
            rsp_valid_q    <= 1'b1;
            rsp_rdata_q    <= write_q ? '0 : rd_data_d;
            rsp_err_q      <= !write_q && rd_err_d;
            rsp_mismatch_q <= !write_q && rd_mis_d;
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q        <= ST_IDLE;
          req_ready_q    <= 1'b1;
          rsp_valid_q    <= 1'b0;
          rsp_err_q      <= 1'b0;
          rsp_mismatch_q <= 1'b0;
          rsp_timeout_q  <= 1'b0;
          rsp_rdata_q    <= '0;
          drv_sel_q      <= '0;
          drv_wdata_q    <= '0;
          cnt_q          <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_mismatch = rsp_mismatch_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign drv_rd       = drv_rd_q;
  assign drv_wr       = drv_wr_q;
  assign drv_sel      = drv_sel_q;
  assign drv_addr     = drv_addr_q;
  assign drv_wdata    = drv_wdata_q;

endmodule

// File: tb/tb_raid_array_ctrl.sv
// Randomized bench for raid_array_ctrl checked against a behavioural RAID model.
module tb_raid_array_ctrl;

  localparam int ND = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   mode, drive_fail, drv_sel, drv_busy;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr, req_wdata, rsp_rdata, drv_addr;
  logic         rsp_valid, rsp_err, rsp_mismatch, rsp_timeout, drv_rd, drv_wr;
  logic [127:0] drv_wdata, drv_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]   cap_sel;
  logic [127:0] cap_wdata;
  logic [31:0]  cap_rdata;
  logic         cap_err, cap_mis, cap_to, cap_strobe;
  int           cap_waits;

  raid_array_ctrl #(.NDRIVES(ND), .SW(8), .AW(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .mode(mode), .drive_fail(drive_fail),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch),
    .rsp_timeout(rsp_timeout), .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_sel(drv_sel), .drv_addr(drv_addr), .drv_wdata(drv_wdata),
    .drv_rdata(drv_rdata), .drv_busy(drv_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_pre_err(input logic [3:0] md, input logic [3:0] fl);
    if (md == 4'd1) return fl != 4'h0;
    if (md == 4'd0) return fl == 4'hF;
    if (md == 4'd5) return $countones(fl) > 1;
    return 1'b1;
  endfunction

  function automatic logic [127:0] lane_mask(input logic [3:0] s);
    logic [127:0] m = '0;
    for (int i = 0; i < ND; i++) if (s[i]) m[i*32 +: 32] = '1;
    return m;
  endfunction

  // What each drive should receive on a write.
  function automatic logic [127:0] exp_lanes(input logic [3:0] md, input logic [3:0] fl,
                                             input logic [31:0] addr, input logic [31:0] wd);
    logic [127:0] r = '0;
    logic [7:0]   units[$];
    logic [7:0]   par = 8'h00;
    int           p = int'(addr % 32'd4);
    if (md == 4'd1) for (int i = 0; i < ND; i++) r[i*32 +: 8] = wd[i*8 +: 8];
    if (md == 4'd0) for (int i = 0; i < ND; i++) r[i*32 +: 32] = wd;
    if (md == 4'd5) begin
      for (int k = 0; k < ND - 1; k++) begin
        units.push_back(wd[k*8 +: 8]);
        par ^= wd[k*8 +: 8];
      end
      for (int i = 0; i < ND; i++) r[i*32 +: 8] = (i == p) ? par : units.pop_front();
    end
    for (int i = 0; i < ND; i++) if (fl[i]) r[i*32 +: 32] = '0;
    return r;
  endfunction

  task automatic exp_read(input logic [3:0] md, input logic [3:0] fl, input logic [31:0] addr,
                          input logic [127:0] lanes, output logic [31:0] rd,
                          output logic err, output logic mis);
    logic [31:0] vals[$];
    logic [7:0]  b[ND];
    logic [7:0]  data[$];
    logic [7:0]  x = 8'h00;
    logic        found = 1'b0;
    int          p = int'(addr % 32'd4);
    int          c;
    rd = '0; err = 1'b0; mis = 1'b0;
    if (md == 4'd1) for (int i = 0; i < ND; i++) rd[i*8 +: 8] = lanes[i*32 +: 8];
    if (md == 4'd0) begin
      for (int i = 0; i < ND; i++) if (!fl[i]) vals.push_back(lanes[i*32 +: 32]);
      foreach (vals[a]) begin
        c = 0;
        foreach (vals[k]) if (vals[k] == vals[a]) c++;
        if (!found && 2 * c > vals.size()) begin
          found = 1'b1;
          rd    = vals[a];
          mis   = (c != vals.size());
        end
      end
      if (!found) begin
        err = 1'b1;
        rd  = 32'hFFFF_FFFF;
      end
    end
    if (md == 4'd5) begin
      for (int i = 0; i < ND; i++) if (!fl[i]) x ^= lanes[i*32 +: 8];
      for (int i = 0; i < ND; i++) b[i] = fl[i] ? x : lanes[i*32 +: 8];
      for (int i = 0; i < ND; i++) if (i != p) data.push_back(b[i]);
      rd  = {8'h00, data[2], data[1], data[0]};
      mis = (fl == 4'h0) && (x != 8'h00);
    end
  endtask

  // One full host transaction with drive emulation and response checking.
  task automatic run_req(input logic wr, input logic [3:0] md, input logic [3:0] fl,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [127:0] lanes, input int bc, input logic [3:0] bmask);
    logic         perr, eerr, emis, eto;
    logic [3:0]   sel, bm;
    logic [127:0] wexp, lm;
    logic [31:0]  rexp;
    int           waits = 0;
    int           exp_waits;
    perr = exp_pre_err(md, fl);
    sel  = perr ? 4'h0 : ~fl;
    check("ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    mode = md; drive_fail = fl; drv_rdata = lanes; drv_busy = 4'h0;
    step();
    mode = 4'($urandom); drive_fail = 4'($urandom); req_write = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_valid = 1'b0;
    check("ready_low", req_ready, 1'b0);
    cap_strobe = drv_rd | drv_wr;
    cap_sel    = drv_sel;
    cap_wdata  = drv_wdata;
    check("drv_rd", drv_rd, !perr && !wr);
    check("drv_wr", drv_wr, !perr && wr);
    check("drv_sel", drv_sel, sel);
    if (!perr) check("drv_addr", drv_addr, addr);
    if (!perr && wr) begin
      wexp = exp_lanes(md, fl, addr, wd);
      lm   = lane_mask(sel);
      check("drv_wdata", drv_wdata & lm, wexp & lm);
    end
    bm = (bmask != 4'h0) ? bmask : (sel & 4'($urandom_range(1, 15)));
    if (bm == 4'h0) bm = sel;
    exp_waits = (bc >= TO) ? TO : bc + 1;
    if (!perr) begin
      step();
      check("strobe_one_cycle", drv_rd | drv_wr, 1'b0);
      while (!rsp_valid && waits < 64) begin
        waits++;
        drv_busy  = ((waits <= bc) ? bm : 4'h0) | (~sel & 4'($urandom));
        req_valid = 1'($urandom);
        step();
      end
      check("wait_cycles", 128'(waits), 128'(exp_waits));
    end
    req_valid = 1'b0;
    drv_busy  = 4'h0;
    eto = 1'b0; emis = 1'b0; eerr = 1'b0; rexp = '0;
    if (perr) eerr = 1'b1;
    else if (bc >= TO) begin eto = 1'b1; eerr = 1'b1; end
    else if (!wr) exp_read(md, fl, addr, lanes, rexp, eerr, emis);
    check("rsp_valid", rsp_valid, 1'b1);
    check("ready_in_resp", req_ready, 1'b0);
    if (!wr && !perr) check("rsp_rdata", rsp_rdata, rexp);
    check("rsp_err", rsp_err, eerr);
    check("rsp_mismatch", rsp_mismatch, emis);
    check("rsp_timeout", rsp_timeout, eto);
    cap_rdata = rsp_rdata; cap_err = rsp_err; cap_mis = rsp_mismatch;
    cap_to = rsp_timeout; cap_waits = waits;
    step();
    check("rsp_one_cycle", rsp_valid, 1'b0);
    check("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    logic [3:0]   md, fl;
    logic [31:0]  addr, v, v2;
    logic [127:0] lanes;
    int           r, bc;

    reset = 1'b0; mode = 4'h0; drive_fail = 4'h0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; drv_rdata = '0; drv_busy = 4'h0;
    step(); step();
    check("rst_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_strobes", {drv_rd, drv_wr}, 2'b00);
    check("rst_sel", drv_sel, 4'h0);
    check("rst_wdata", drv_wdata, 128'h0);
    check("rst_flags", {rsp_err, rsp_mismatch, rsp_timeout}, 3'b000);
    reset = 1'b1;
    step();

    run_req(1'b1, 4'd5, 4'h0, 32'd5, 32'h00CC_BBAA, '0, 2, 4'h0);
    check("r5w_lanes", cap_wdata, 128'h0000_00CC_0000_00BB_0000_00DD_0000_00AA);
    check("r5w_sel", cap_sel, 4'hF);

    run_req(1'b0, 4'd5, 4'b0100, 32'd5, 32'h0,
            {32'h0000_00CC, 32'h5A5A_5A5A, 32'h0000_00DD, 32'h0000_00AA}, 1, 4'h0);
    check("r5r_rdata", cap_rdata, 32'h00CC_BBAA);
    check("r5r_sel", cap_sel, 4'b1011);
    check("r5r_flags", {cap_mis, cap_err}, 2'b00);

    run_req(1'b0, 4'd0, 4'h0, 32'd9, 32'h0,
            {32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678}, 0, 4'h0);
    check("r1_minority_rdata", cap_rdata, 32'h1234_5678);
    check("r1_minority_flags", {cap_mis, cap_err}, 2'b10);

    run_req(1'b0, 4'd0, 4'h0, 32'd10, 32'h0,
            {32'h2222_2222, 32'h2222_2222, 32'h1111_1111, 32'h1111_1111}, 0, 4'h0);
    check("r1_split_rdata", cap_rdata, 32'hFFFF_FFFF);
    check("r1_split_err", cap_err, 1'b1);

    run_req(1'b0, 4'd1, 4'h0, 32'd3, 32'h0, {4{32'h0102_0304}}, 1000, 4'b1000);
    check("to_waits", 128'(cap_waits), 128'(TO));
    check("to_flags", {cap_to, cap_err}, 2'b11);
    check("to_rdata", cap_rdata, 32'h0);

    run_req(1'b0, 4'd1, 4'b0001, 32'd3, 32'h0, '0, 0, 4'h0);
    check("r0fail_no_strobe", cap_strobe, 1'b0);
    check("r0fail_err", cap_err, 1'b1);

    // Reset during WAIT of a RAID5 write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd6; req_wdata = 32'h0011_2233;
    mode = 4'd5; drive_fail = 4'h0;
    step();
    req_valid = 1'b0;
    drv_busy = 4'hF;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_mid_ready", req_ready, 1'b1);
    check("rst_mid_sel", drv_sel, 4'h0);
    r = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (rsp_valid) r++;
    end
    check("rst_mid_no_rsp", 128'(r), 128'h0);
    reset = 1'b1;
    drv_busy = 4'h0;
    step();
    check("rst_release_ready", req_ready, 1'b1);
    check("rst_release_rsp", rsp_valid, 1'b0);
    run_req(1'b1, 4'd5, 4'h0, 32'd6, 32'h0011_2233, '0, 0, 4'h0);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r < 3) md = 4'd1;
      else if (r < 6) md = 4'd0;
      else if (r < 9) md = 4'd5;
      else begin
        md = 4'($urandom_range(2, 15));
        if (md == 4'd5) md = 4'd7;
      end
      r = $urandom_range(0, 3);
      fl = (r < 2) ? 4'h0 : (r == 2) ? (4'h1 << $urandom_range(0, 3)) : 4'($urandom);
      addr = $urandom;
      bc = ($urandom_range(0, 19) == 0) ? TO + 4 : $urandom_range(0, 4);
      lanes = {$urandom, $urandom, $urandom, $urandom};
      if (md == 4'd0) begin
        v = $urandom; v2 = $urandom;
        for (int i = 0; i < ND; i++) lanes[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? v2 : v;
      end else if (md == 4'd5) begin
        lanes = exp_lanes(4'd5, 4'h0, addr, $urandom);
        for (int i = 0; i < ND; i++) lanes[i*32 + 8 +: 24] = 24'($urandom);
        if ($urandom_range(0, 3) == 0)
          lanes[$urandom_range(0, 3)*32 +: 8] ^= 8'($urandom_range(1, 255));
        for (int i = 0; i < ND; i++) if (fl[i]) lanes[i*32 +: 32] = $urandom;
      end
      run_req(1'($urandom), md, fl, addr, $urandom, lanes, bc, 4'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
